// File: rtl/decod.sv
// Hamming(7,4) single-error-correcting decoder with one registered output stage.
// Bit i of every codeword holds Hamming position i+1.
module decod (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [6:0] data_h_in,
  output logic [6:0] data_out,
  output logic [3:0] data_nib,
  output logic       out_valid,
  output logic       err_det,
  output logic [2:0] err_pos
);

  logic [2:0] syn_s;
  logic [6:0] flip_mask_s;

  logic [6:0] data_out_d, data_out_q;
  logic [3:0] data_nib_d, data_nib_q;
  logic       out_valid_d, out_valid_q;
  logic       err_det_d, err_det_q;
  logic [2:0] err_pos_d, err_pos_q;

  // Each syndrome bit re-checks one parity group; together they name the bad position.
  function automatic logic [2:0] hamming_syndrome(input logic [6:0] w);
    logic s1, s2, s4;
    s1 = w[0] ^ w[2] ^ w[4] ^ w[6];
    s2 = w[1] ^ w[2] ^ w[5] ^ w[6];
    s4 = w[3] ^ w[4] ^ w[5] ^ w[6];
    return {s4, s2, s1};
  endfunction

  // Syndrome decode, single-bit correction and next-state values for the output stage.
  always_comb begin
    syn_s = hamming_syndrome(data_h_in);
    case (syn_s)
      3'd1:    flip_mask_s = 7'b0000001;
      3'd2:    flip_mask_s = 7'b0000010;
      3'd3:    flip_mask_s = 7'b0000100;
      3'd4:    flip_mask_s = 7'b0001000;
      3'd5:    flip_mask_s = 7'b0010000;
      3'd6:    flip_mask_s = 7'b0100000;
      3'd7:    flip_mask_s = 7'b1000000;
      default: flip_mask_s = 7'b0000000;
    endcase
    data_out_d  = data_h_in ^ flip_mask_s;
    data_nib_d  = {data_out_d[6], data_out_d[5], data_out_d[4], data_out_d[2]};
    err_pos_d   = syn_s;
    err_det_d   = |syn_s;
    out_valid_d = in_valid;
  end

  // Output stage loads every cycle; out_valid tells downstream which results matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q  <= 7'b0000000;
      data_nib_q  <= 4'b0000;
      out_valid_q <= 1'b0;
      err_det_q   <= 1'b0;
      err_pos_q   <= 3'b000;
    end else begin
      data_out_q  <= data_out_d;
      data_nib_q  <= data_nib_d;
      out_valid_q <= out_valid_d;
      err_det_q   <= err_det_d;
      err_pos_q   <= err_pos_d;
    end
  end

  assign data_out  = data_out_q;
  assign data_nib  = data_nib_q;
  assign out_valid = out_valid_q;
  assign err_det   = err_det_q;
  assign err_pos   = err_pos_q;

endmodule

// File: tb/tb_decod.sv
// Bench for decod: directed cases, exhaustive single-error sweep and random words
// checked against a position-XOR Hamming model.
module tb_decod;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [6:0] data_h_in;
  logic [6:0] data_out;
  logic [3:0] data_nib;
  logic       out_valid;
  logic       err_det;
  logic [2:0] err_pos;

  int total = 0;
  int bad   = 0;

  decod dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_h_in(data_h_in),
    .data_out(data_out), .data_nib(data_nib), .out_valid(out_valid),
    .err_det(err_det), .err_pos(err_pos)
  );

  always #5 clk = ~clk;

  // Syndrome as the XOR of the position numbers of every set bit.
  function automatic logic [2:0] m_syn(input logic [6:0] w);
    logic [2:0] s;
    s = 3'd0;
    for (int k = 1; k <= 7; k++) if (w[k-1]) s = s ^ 3'(k);
    return s;
  endfunction

  // Encode: data into positions 3,5,6,7, then each parity bit makes its group even.
  function automatic logic [6:0] m_enc(input logic [3:0] d);
    logic [6:0] w;
    w = 7'd0;
    w[2] = d[0]; w[4] = d[1]; w[5] = d[2]; w[6] = d[3];
    for (int p = 1; p <= 4; p = p * 2) begin
      logic par;
      par = 1'b0;
      for (int k = 1; k <= 7; k++) if ((k & p) != 0) par = par ^ w[k-1];
      w[p-1] = par;
    end
    return w;
  endfunction

  function automatic logic [6:0] m_fix(input logic [6:0] w);
    logic [6:0] c;
    logic [2:0] s;
    c = w;
    s = m_syn(w);
    if (s != 3'd0) c[s-1] = ~c[s-1];
    return c;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout"}, {1'b0, data_out}, 8'd0);
    check({tag, "_nib"},  {4'd0, data_nib}, 8'd0);
    check({tag, "_ov"},   {7'd0, out_valid}, 8'd0);
    check({tag, "_det"},  {7'd0, err_det}, 8'd0);
    check({tag, "_pos"},  {5'd0, err_pos}, 8'd0);
  endtask

  // Apply one word, wait one edge, compare all outputs against the model.
  task automatic step(input string tag, input logic v, input logic [6:0] w);
    logic [6:0] c;
    @(negedge clk);
    in_valid  = v;
    data_h_in = w;
    @(posedge clk);
    #1;
    c = m_fix(w);
    check({tag, "_dout"}, {1'b0, data_out}, {1'b0, c});
    check({tag, "_nib"},  {4'd0, data_nib}, {4'd0, c[6], c[5], c[4], c[2]});
    check({tag, "_ov"},   {7'd0, out_valid}, {7'd0, v});
    check({tag, "_det"},  {7'd0, err_det}, {7'd0, (m_syn(w) != 3'd0)});
    check({tag, "_pos"},  {5'd0, err_pos}, {5'd0, m_syn(w)});
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    data_h_in = 7'd0;
    #3;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the test plan, with literal expectations as well.
    step("all_ones", 1'b1, 7'b1111111);
    check("all_ones_lit", {1'b0, data_out}, 8'h7F);
    check("all_ones_nib", {4'd0, data_nib}, 8'h0F);
    step("s7", 1'b1, 7'b1000111);
    check("s7_lit", {1'b0, data_out}, 8'h07);
    check("s7_nib", {4'd0, data_nib}, 8'h01);
    check("s7_pos", {5'd0, err_pos}, 8'd7);
    step("zero", 1'b1, 7'b0000000);
    check("zero_det", {7'd0, err_det}, 8'd0);
    step("p1", 1'b1, 7'b0000001);
    check("p1_lit", {1'b0, data_out}, 8'h00);
    check("p1_pos", {5'd0, err_pos}, 8'd1);
    check("p1_det", {7'd0, err_det}, 8'd1);

    // Every nibble with every single-bit error position.
    for (int d = 0; d < 16; d++) begin
      for (int p = 1; p <= 7; p++) begin
        logic [6:0] clean;
        clean = m_enc(4'(d));
        step("sweep", 1'(p & 1), clean ^ (7'd1 << (p - 1)));
        check("sweep_clean", {1'b0, data_out}, {1'b0, clean});
        check("sweep_epos", {5'd0, err_pos}, 8'(p));
        check("sweep_data", {4'd0, data_nib}, 8'(d));
      end
      step("clean", 1'b1, m_enc(4'(d)));
    end

    // Random received words, including double errors that get miscorrected.
    for (int i = 0; i < 60; i++) begin
      step("rand", 1'($urandom_range(1)), 7'($urandom));
    end

    // Asynchronous reset between edges, then release with a word applied.
    step("pre_rst", 1'b1, 7'b1111111);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    in_valid  = 1'b1;
    data_h_in = 7'b1000111;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    check("rel_dout", {1'b0, data_out}, 8'h07);
    check("rel_ov", {7'd0, out_valid}, 8'd1);

    // in_valid toggling with a fresh word every cycle.
    step("tog1", 1'b1, 7'b0110011);
    step("tog0", 1'b0, 7'b1010101);
    check("tog0_ov", {7'd0, out_valid}, 8'd0);
    step("tog1b", 1'b1, 7'b0001111);
    check("tog1b_ov", {7'd0, out_valid}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decod.md
Name: decod

Overview:
- Single-error-correcting Hamming(7,4) decoder in the Hamming datapath.
- Takes a 7-bit received codeword, computes the 3-bit syndrome, flips the erroneous bit if there is one, and presents the corrected codeword, the extracted 4-bit data nibble and error status.
- Outputs are registered: one clock of latency, free-running, with a valid flag carried alongside.

Parameters:
- None. Codeword width is fixed at 7 and data width at 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies data_h_in on this cycle
- data_h_in  input  7  received codeword; bit i holds Hamming position i+1
- data_out  output  7  corrected codeword, same bit mapping as data_h_in
- data_nib  output  4  corrected data bits {pos7,pos6,pos5,pos3} = {b6,b5,b4,b2}
- out_valid  output  1  in_valid delayed by one cycle
- err_det  output  1  syndrome was nonzero and a bit was corrected
- err_pos  output  3  syndrome value: 1..7 gives the corrected position, 0 means no error

Behaviour:
- Bit mapping:
  - Parity bits: b0 = p1, b1 = p2, b3 = p4.
  - Data bits: b2 = d1, b4 = d2, b5 = d3, b6 = d4.
- Syndrome (combinational, from data_h_in):
  - s1 = b0^b2^b4^b6
  - s2 = b1^b2^b5^b6
  - s4 = b3^b4^b5^b6
  - S = {s4,s2,s1}
- Correction:
  - If S == 0, corrected word equals data_h_in.
  - Otherwise the corrected word is data_h_in with bit (S-1) inverted. Exactly one bit is flipped.
  - Double errors are miscorrected; detecting them is out of scope.
- Registers on every rising clk:
  - data_out <= corrected word
  - data_nib <= {c6,c5,c4,c2}
  - err_pos <= S
  - err_det <= |S
  - out_valid <= in_valid
- Registers load every cycle regardless of in_valid; downstream logic qualifies them with out_valid.
- Latency: exactly 1 cycle from data_h_in/in_valid to the outputs. Back-to-back inputs are accepted every cycle with no stall.
- Reset:
  - While rst_n = 0, all outputs are 0 (data_out = 7'b0, data_nib = 0, err_pos = 0, err_det = 0, out_valid = 0). This takes effect immediately, without waiting for clk.
  - Deasserting reset mid-stream: the first rising edge after rst_n goes high captures the current input normally.
- X/undefined input handling is not required.

Test Plan:
- 7'b1111111, in_valid = 1 -> next cycle: data_out = 7'b1111111, data_nib = 4'b1111, err_det = 0, err_pos = 0, out_valid = 1.
- 7'b1000111 -> S = 7, bit6 flipped -> data_out = 7'b0000111, data_nib = 4'b0001, err_det = 1, err_pos = 3'd7.
- 7'b0000000, then 7'b0000001 (p1 flipped) -> first result: data_out = 7'b0000000, err_det = 0. Second result: data_out = 7'b0000000, err_pos = 1, err_det = 1.
- Exhaustive sweep, every 4-bit data value: encode, apply each single-bit flip at positions 1..7 -> data_out equals the clean codeword, err_pos equals the flipped position, data_nib equals the original data.
- Assert rst_n = 0 while outputs are nonzero -> all outputs are 0 immediately, before the next clk edge. Release reset with 7'b1000111 applied -> the first edge yields data_out = 7'b0000111.
- Toggle in_valid 1,0,1 with a new word every cycle -> out_valid follows 1,0,1 one cycle later, and data_out updates every cycle.
